// File: rtl/cp_spi_pkg.sv
// Shared types and sizing helpers for the SPI master controller.
`timescale 1ns/1ps
package cp_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cp_spi_sclk_gen.sv
// SCLK generator: half-period counter producing the idle-low SPI clock and
// single-cycle rise/fall strobes; held in reset whenever not enabled.
`timescale 1ns/1ps
module cp_spi_sclk_gen
    import cp_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_aclk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_tick;

    assign w_tick = i_en && (r_cnt == HALF_LAST);

    always_ff @(posedge i_aclk) begin
        if (i_reset || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Strobes coincide with the edge that flips the registered sclk.
    assign o_sclk = r_sclk;
    assign o_rise = w_tick && !r_sclk;
    assign o_fall = w_tick &&  r_sclk;

endmodule

// File: rtl/cp_spi_master_ctrl.sv
// Mode-0 SPI master: one full-duplex MSB-first frame per accepted start,
// with programmable chip-select setup, hold and inter-frame gap.
`timescale 1ns/1ps
module cp_spi_master_ctrl
    import cp_spi_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_GAP     = 2
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int BW   = cnt_width(DATA_WIDTH);
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                               : ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
    localparam int TW   = cnt_width(TMAX);

    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

    spi_state_t            r_state;
    logic [DATA_WIDTH-2:0] r_tx_sr;   // bits still to be sent after the one on mosi
    logic [DATA_WIDTH-1:0] r_rx_sr;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [BW-1:0]         r_bit_cnt;
    logic [TW-1:0]         r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cs_n;
    logic                  r_mosi;

    logic w_shift_en;
    logic w_sclk;
    logic w_rise;
    logic w_fall;

    assign w_shift_en = (r_state == ST_SHIFT);

    cp_spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_aclk  (aclk),
        .i_reset (reset),
        .i_en    (w_shift_en),
        .o_sclk  (w_sclk),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tx_sr   <= tx_data[DATA_WIDTH-2:0];
                        r_mosi    <= tx_data[DATA_WIDTH-1];
                        r_bit_cnt <= '0;
                        r_cnt     <= '0;
                        r_cs_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_rx_sr <= {r_rx_sr[DATA_WIDTH-2:0], spi_miso};
                    end
                    // The last falling edge ends the frame and leaves mosi on the final bit.
                    if (w_fall) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_mosi  <= r_tx_sr[DATA_WIDTH-2];
                            r_tx_sr <= r_tx_sr << 1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt     <= '0;
                        r_cs_n    <= 1'b1;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx_sr;
                        r_state   <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_data  = r_rx_data;
    assign spi_sclk = w_sclk;
    assign spi_cs_n = r_cs_n;
    assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_cp_spi_master_ctrl.sv
// Directed bench for cp_spi_master_ctrl: a 16-bit/CLK_DIV=2 instance and an
// 8-bit/CLK_DIV=1 instance, each frame measured cycle by cycle.
`timescale 1ns/1ps
module tb_cp_spi_master_ctrl;

    localparam int DW   = 16;
    localparam int CD   = 2;
    localparam int SU   = 2;
    localparam int HO   = 2;
    localparam int GA   = 2;
    localparam int WIN  = SU + 2*CD*DW + HO;   // 68
    localparam int DW_B = 8;
    localparam int CD_B = 1;
    localparam int WIN_B = SU + 2*CD_B*DW_B + HO; // 20

    logic aclk;
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Instance A
    logic          a_rst, a_start, a_busy, a_done, a_sclk, a_cs_n, a_mosi, a_miso;
    logic [DW-1:0] a_tx, a_rx;
    // Instance B
    logic            b_rst, b_start, b_busy, b_done, b_sclk, b_cs_n, b_mosi, b_miso;
    logic [DW_B-1:0] b_tx, b_rx;

    // Slave model for A: presents slave_word MSB first, advancing on sclk falls.
    logic          a_mode;
    logic [DW-1:0] slave_word;
    int            s_idx = DW-1;
    always @(negedge a_cs_n) s_idx = DW-1;
    always @(negedge a_sclk) if (!a_cs_n && s_idx > 0) s_idx = s_idx - 1;
    assign a_miso = a_mode ? slave_word[s_idx] : a_mosi;
    assign b_miso = b_mosi;

    cp_spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GA)) u_dut (
        .aclk(aclk), .reset(a_rst), .tx_data(a_tx), .start(a_start), .busy(a_busy), .done(a_done),
        .rx_data(a_rx), .spi_sclk(a_sclk), .spi_cs_n(a_cs_n), .spi_mosi(a_mosi), .spi_miso(a_miso));

    cp_spi_master_ctrl #(.DATA_WIDTH(DW_B), .CLK_DIV(CD_B), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GA)) u_dut_b (
        .aclk(aclk), .reset(b_rst), .tx_data(b_tx), .start(b_start), .busy(b_busy), .done(b_done),
        .rx_data(b_rx), .spi_sclk(b_sclk), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi), .spi_miso(b_miso));

    int n_cmp = 0;
    int n_bad = 0;

    // Runs one frame on A and measures it; start optionally re-pulsed at cycle hijack_k.
    task automatic run_a(input logic [DW-1:0] word, input int hijack_k,
                         output int cs_low, output int rises, output logic [DW-1:0] mosi_word,
                         output int done_lat, output int done_cnt, output logic [DW-1:0] rx_at_done,
                         output bit rx_early);
        logic          prev_sclk;
        logic [DW-1:0] rx_before;
        cs_low = 0; rises = 0; mosi_word = '0; done_lat = -1; done_cnt = 0;
        rx_at_done = '0; rx_early = 1'b0;
        rx_before = a_rx;
        @(negedge aclk); a_tx = word; a_start = 1'b1;
        @(negedge aclk); a_start = 1'b0; a_tx = ~word;
        prev_sclk = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (!a_cs_n) cs_low++;
            if (a_sclk && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[DW-2:0], a_mosi};
            end
            prev_sclk = a_sclk;
            if (a_done) begin
                done_cnt++;
                if (done_lat < 0) begin
                    done_lat   = k;
                    rx_at_done = a_rx;
                end
            end else if (done_cnt == 0 && a_rx !== rx_before) begin
                rx_early = 1'b1;
            end
            if (k == hijack_k) begin
                a_start = 1'b1; a_tx = 16'hFFFF;
            end else begin
                a_start = 1'b0;
            end
            if (k > 1 && !a_busy) break;
            @(negedge aclk);
        end
        a_start = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        a_tx = '0; b_tx = '0; a_mode = 1'b0; slave_word = '0;
        repeat (3) @(negedge aclk);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge aclk);
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
        n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", a_done); end
        n_cmp++; if (a_rx !== 16'h0) begin n_bad++; $display("FAIL rst_rx: got %h expected 0000", a_rx); end
        n_cmp++; if (a_sclk !== 1'b0) begin n_bad++; $display("FAIL rst_sclk: got %b expected 0", a_sclk); end
        n_cmp++; if (a_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b expected 1", a_cs_n); end
        n_cmp++; if (a_mosi !== 1'b0) begin n_bad++; $display("FAIL rst_mosi: got %b expected 0", a_mosi); end
        n_cmp++; if ({b_cs_n, b_sclk, b_busy} !== 3'b100) begin n_bad++; $display("FAIL rst_b_ctrl: got %b expected 100", {b_cs_n, b_sclk, b_busy}); end
    endtask

    task automatic test_basic();
        int cs_low, rises, lat, dcnt; logic [DW-1:0] mw, rx; bit early;
        a_mode = 1'b0;
        run_a(16'hA5C3, -1, cs_low, rises, mw, lat, dcnt, rx, early);
        n_cmp++; if (cs_low != WIN) begin n_bad++; $display("FAIL basic_cs_low: got %0d expected %0d", cs_low, WIN); end
        n_cmp++; if (rises != DW) begin n_bad++; $display("FAIL basic_rises: got %0d expected %0d", rises, DW); end
        n_cmp++; if (mw !== 16'hA5C3) begin n_bad++; $display("FAIL basic_mosi: got %h expected a5c3", mw); end
        n_cmp++; if (lat != WIN + 1) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", lat, WIN + 1); end
        n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d expected 1", dcnt); end
        n_cmp++; if (rx !== 16'hA5C3) begin n_bad++; $display("FAIL basic_rx: got %h expected a5c3", rx); end
    endtask

    task automatic test_indep_miso();
        int cs_low, rises, lat, dcnt; logic [DW-1:0] mw, rx; bit early;
        a_mode = 1'b1; slave_word = 16'h1234;
        run_a(16'h0F0F, -1, cs_low, rises, mw, lat, dcnt, rx, early);
        a_mode = 1'b0;
        n_cmp++; if (rx !== 16'h1234) begin n_bad++; $display("FAIL miso_rx: got %h expected 1234", rx); end
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL miso_rx_early_change: got %b expected 0", early); end
        n_cmp++; if (mw !== 16'h0F0F) begin n_bad++; $display("FAIL miso_mosi: got %h expected 0f0f", mw); end
        repeat (20) @(negedge aclk);
        n_cmp++; if (a_rx !== 16'h1234) begin n_bad++; $display("FAIL miso_rx_held: got %h expected 1234", a_rx); end
    endtask

    task automatic test_start_while_busy();
        int cs_low, rises, lat, dcnt, extra_low; logic [DW-1:0] mw, rx; bit early;
        run_a(16'h5A5A, 30, cs_low, rises, mw, lat, dcnt, rx, early);
        extra_low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (!a_cs_n) extra_low++;
        end
        n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL busy_done_cnt: got %0d expected 1", dcnt); end
        n_cmp++; if (mw !== 16'h5A5A) begin n_bad++; $display("FAIL busy_mosi: got %h expected 5a5a", mw); end
        n_cmp++; if (extra_low != 0) begin n_bad++; $display("FAIL busy_no_queue: got %0d expected 0", extra_low); end
        n_cmp++; if (a_rx !== 16'h5A5A) begin n_bad++; $display("FAIL busy_rx: got %h expected 5a5a", a_rx); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, gap_hi, wait_k; bit in_gap, gap_closed; logic [DW-1:0] rx2;
        d1 = -1; d2 = -1; gap_hi = 0; in_gap = 1'b0; gap_closed = 1'b0; rx2 = '0;
        @(negedge aclk); a_tx = 16'hC3A5; a_start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge aclk);
            if (a_done) begin
                if (d1 < 0) begin d1 = k; in_gap = 1'b1; end
                else if (d2 < 0) begin d2 = k; rx2 = a_rx; end
            end
            if (in_gap && !gap_closed) begin
                if (a_cs_n) gap_hi++;
                else gap_closed = 1'b1;
            end
            if (d2 >= 0) break;
        end
        a_start = 1'b0;
        wait_k = 0;
        while (a_busy && wait_k < 200) begin
            @(negedge aclk);
            wait_k++;
        end
        n_cmp++; if (d2 - d1 != 1 + WIN + GA) begin n_bad++; $display("FAIL b2b_done_period: got %0d expected %0d", d2 - d1, 1 + WIN + GA); end
        n_cmp++; if (gap_hi != GA + 1) begin n_bad++; $display("FAIL b2b_cs_high: got %0d expected %0d", gap_hi, GA + 1); end
        n_cmp++; if (rx2 !== 16'hC3A5) begin n_bad++; $display("FAIL b2b_rx: got %h expected c3a5", rx2); end
        n_cmp++; if (wait_k >= 200) begin n_bad++; $display("FAIL b2b_idle_timeout: got %0d expected <200", wait_k); end
    endtask

    task automatic test_clkdiv1();
        int cs_low, rises, first_r, last_r, highs, lat, prev_r; bit bad_period;
        logic prev_sclk; logic [DW_B-1:0] mw, rx;
        cs_low = 0; rises = 0; first_r = -1; last_r = -1; highs = 0; lat = -1;
        prev_r = -1; bad_period = 1'b0; prev_sclk = 1'b0; mw = '0; rx = '0;
        @(negedge aclk); b_tx = 8'h81; b_start = 1'b1;
        @(negedge aclk); b_start = 1'b0; b_tx = 8'h00;
        for (int k = 1; k <= 100; k++) begin
            if (!b_cs_n) cs_low++;
            if (b_sclk) highs++;
            if (b_sclk && !prev_sclk) begin
                rises++;
                mw = {mw[DW_B-2:0], b_mosi};
                if (first_r < 0) first_r = k;
                if (prev_r >= 0 && k - prev_r != 2) bad_period = 1'b1;
                prev_r = k; last_r = k;
            end
            prev_sclk = b_sclk;
            if (b_done && lat < 0) begin lat = k; rx = b_rx; end
            if (k > 1 && !b_busy) break;
            @(negedge aclk);
        end
        n_cmp++; if (cs_low != WIN_B) begin n_bad++; $display("FAIL cd1_cs_low: got %0d expected %0d", cs_low, WIN_B); end
        n_cmp++; if (rises != DW_B) begin n_bad++; $display("FAIL cd1_rises: got %0d expected %0d", rises, DW_B); end
        n_cmp++; if (bad_period || last_r - first_r != 2*(DW_B-1)) begin n_bad++; $display("FAIL cd1_period: got span %0d expected %0d", last_r - first_r, 2*(DW_B-1)); end
        n_cmp++; if (highs != DW_B) begin n_bad++; $display("FAIL cd1_high_cycles: got %0d expected %0d", highs, DW_B); end
        n_cmp++; if (mw !== 8'h81) begin n_bad++; $display("FAIL cd1_mosi: got %h expected 81", mw); end
        n_cmp++; if (lat != WIN_B + 1) begin n_bad++; $display("FAIL cd1_latency: got %0d expected %0d", lat, WIN_B + 1); end
        n_cmp++; if (rx !== 8'h81) begin n_bad++; $display("FAIL cd1_rx: got %h expected 81", rx); end
    endtask

    task automatic test_reset_mid();
        int cs_low, rises, lat, dcnt, stray_done, stray_low; logic [DW-1:0] mw, rx; bit early;
        n_cmp++; if (a_rx === 16'h0) begin n_bad++; $display("FAIL rmid_rx_pre: got %h expected nonzero", a_rx); end
        @(negedge aclk); a_tx = 16'h9E37; a_start = 1'b1;
        @(negedge aclk); a_start = 1'b0;
        for (int k = 1; k < 20; k++) @(negedge aclk);
        a_rst = 1'b1;
        @(negedge aclk);
        n_cmp++; if (a_cs_n !== 1'b1) begin n_bad++; $display("FAIL rmid_cs_n: got %b expected 1", a_cs_n); end
        n_cmp++; if (a_sclk !== 1'b0) begin n_bad++; $display("FAIL rmid_sclk: got %b expected 0", a_sclk); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", a_busy); end
        n_cmp++; if (a_rx !== 16'h0) begin n_bad++; $display("FAIL rmid_rx: got %h expected 0000", a_rx); end
        a_rst = 1'b0;
        stray_done = 0; stray_low = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_done) stray_done++;
            if (!a_cs_n) stray_low++;
            @(negedge aclk);
        end
        n_cmp++; if (stray_done != 0 || stray_low != 0) begin n_bad++; $display("FAIL rmid_no_done: got done=%0d low=%0d expected 0/0", stray_done, stray_low); end
        run_a(16'h3C96, -1, cs_low, rises, mw, lat, dcnt, rx, early);
        n_cmp++; if (lat != WIN + 1) begin n_bad++; $display("FAIL rmid_latency: got %0d expected %0d", lat, WIN + 1); end
        n_cmp++; if (cs_low != WIN) begin n_bad++; $display("FAIL rmid_cs_low: got %0d expected %0d", cs_low, WIN); end
        n_cmp++; if (mw !== 16'h3C96 || rx !== 16'h3C96) begin n_bad++; $display("FAIL rmid_frame: got mosi %h rx %h expected 3c96", mw, rx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_indep_miso();
        test_start_while_busy();
        test_back_to_back();
        test_clkdiv1();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
